recip_share_arbiter: RTL and testbench

//  Shares one iterative reciprocal unit (inv) between NUM_REQ triangle-setup lanes. Each lane issues a

---
 rtl/recip_share_arbiter_pkg.sv | 21 ++
 rtl/recip_share_arbiter_rr_pick.sv | 38 +++
 rtl/recip_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_recip_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recip_share_arbiter_pkg.sv
// Shared types for the reciprocal-unit arbiter: result slot payload and FSM states.
package recip_share_arbiter_pkg;

  // Width of the reciprocal carried in a result slot (DENOM_INV_BITS).
  localparam int unsigned RECIP_Y_BITS = 36;

  // Per-lane result payload, MSB first: {y, ok, dbz, ovf}.
  typedef struct packed {
    logic signed [RECIP_Y_BITS-1:0] y;
    logic                           ok;
    logic                           dbz;
    logic                           ovf;
  } recip_result_t;

  typedef enum logic [1:0] {
    RA_IDLE   = 2'd0,
    RA_LAUNCH = 2'd1,
    RA_WAIT   = 2'd2
  } recip_arb_state_e;

endpackage

// File: rtl/recip_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning upward from ptr_i with wrap.
// Ports:
//   req_i   [N]   request vector
//   ptr_i   [PW]  scan start index (< N)
//   gnt_o   [N]   one-hot grant (0 when nothing requested)
//   idx_o   [PW]  index of the granted bit
//   any_o         some bit of req_i is set
module recip_share_arbiter_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int   c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < int'(N); k++) begin
      c = int'(ptr_i) + k;
      if (c >= int'(N)) c = c - int'(N);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = PW'(c);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/recip_share_arbiter.sv
// Shares one iterative reciprocal unit between NUM_REQ triangle-setup lanes, round-robin,
// one operation in flight. Each lane owns a result slot that drains independently.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid_i/req_ready_o/req_x_i   per-lane denominator request (ready is combinational, IDLE only)
//   resp_valid_o/resp_ready_i/resp_data_o  per-lane result slot {y, ok, dbz, ovf}
//   inv_start_o/inv_x_o            start pulse and held operand to the reciprocal unit
//   inv_busy_i/inv_done_i/inv_valid_i/inv_dbz_i/inv_ovf_i/inv_y_i  reciprocal unit status/result
//   busy_o                         FSM not idle or any slot full
//   err_timeout_o                  sticky: an operation was aborted by timeout
module recip_share_arbiter
  import recip_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned IN_BITS        = 40,
  parameter int unsigned OUT_BITS       = RECIP_Y_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ*IN_BITS-1:0]          req_x_i,
  output logic [NUM_REQ-1:0]                  resp_valid_o,
  input  logic [NUM_REQ-1:0]                  resp_ready_i,
  output logic [NUM_REQ*$bits(recip_result_t)-1:0] resp_data_o,
  output logic                                inv_start_o,
  output logic [IN_BITS-1:0]                  inv_x_o,
  input  logic                                inv_busy_i,
  input  logic                                inv_done_i,
  input  logic                                inv_valid_i,
  input  logic                                inv_dbz_i,
  input  logic                                inv_ovf_i,
  input  logic [OUT_BITS-1:0]                 inv_y_i,
  output logic                                busy_o,
  output logic                                err_timeout_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RES_W = $bits(recip_result_t);

  recip_arb_state_e     state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [IN_BITS-1:0]   inv_x_q;
  logic                 inv_start_q;
  logic [TMR_W-1:0]     timer_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  recip_result_t        slot_q [NUM_REQ];
  logic                 err_timeout_q;

  logic [NUM_REQ-1:0]   eligible_c;
  logic [NUM_REQ-1:0]   pick_gnt_c;
  logic [PTR_W-1:0]     pick_idx_c;
  logic                 pick_any_c;
  logic                 grant_c;
  logic [IN_BITS-1:0]   x_sel_c;
  logic [PTR_W-1:0]     rr_next_c;

  // A lane with a full slot is skipped so it cannot stall the others.
  assign eligible_c = req_valid_i & ~resp_valid_q;

  recip_share_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_pick (
    .req_i (eligible_c),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_c),
    .idx_o (pick_idx_c),
    .any_o (pick_any_c)
  );

  assign grant_c     = (state_q == RA_IDLE) && !inv_busy_i && pick_any_c;
  assign req_ready_o = grant_c ? pick_gnt_c : '0;
  assign x_sel_c     = req_x_i[int'(pick_idx_c)*IN_BITS +: IN_BITS];
  assign rr_next_c   = (pick_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + PTR_W'(1);

  // Arbitration FSM, operand/timer datapath and per-lane result slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RA_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      inv_x_q       <= '0;
      inv_start_q   <= 1'b0;
      timer_q       <= '0;
      resp_valid_q  <= '0;
      err_timeout_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) slot_q[i] <= '0;
    end else begin
      inv_start_q <= 1'b0;

      // Drain: the owner slot is empty at grant, so this never collides with a write.
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (resp_valid_q[i] && resp_ready_i[i]) begin
          resp_valid_q[i] <= 1'b0;
          slot_q[i]       <= '0;
        end
      end

      case (state_q)
        RA_IDLE: begin
          if (grant_c) begin
            owner_q     <= pick_idx_c;
            inv_x_q     <= x_sel_c;
            rr_ptr_q    <= rr_next_c;
            inv_start_q <= 1'b1;
            state_q     <= RA_LAUNCH;
          end
        end
        RA_LAUNCH: begin
          timer_q <= '0;
          state_q <= RA_WAIT;
        end
        RA_WAIT: begin
          if (inv_done_i) begin
            slot_q[owner_q].y   <= RECIP_Y_BITS'(inv_y_i);
            slot_q[owner_q].ok  <= inv_valid_i;
            slot_q[owner_q].dbz <= inv_dbz_i;
            slot_q[owner_q].ovf <= inv_ovf_i;
            resp_valid_q[owner_q] <= 1'b1;
            state_q <= RA_IDLE;
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Deliver an ok=0 result so the lane can drop its triangle.
            slot_q[owner_q]       <= '0;
            resp_valid_q[owner_q] <= 1'b1;
            err_timeout_q         <= 1'b1;
            state_q               <= RA_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= RA_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_resp
    assign resp_data_o[g*RES_W +: RES_W] = slot_q[g];
  end

  assign resp_valid_o  = resp_valid_q;
  assign inv_start_o   = inv_start_q;
  assign inv_x_o       = inv_x_q;
  assign busy_o        = (state_q != RA_IDLE) || (|resp_valid_q);
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_recip_share_arbiter.sv
module tb_recip_share_arbiter;
  import recip_share_arbiter_pkg::*;

  localparam int NR   = 2;
  localparam int IB   = 40;
  localparam int OB   = 36;
  localparam int RW   = $bits(recip_result_t);
  localparam int LAT  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*IB-1:0]  req_x = '0;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready = '0;
  logic [NR*RW-1:0]  resp_data;
  logic              inv_start;
  logic [IB-1:0]     inv_x;
  logic              inv_busy, inv_done, inv_valid, inv_dbz, inv_ovf;
  logic [OB-1:0]     inv_y;
  logic              busy, err_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  recip_share_arbiter #(.NUM_REQ(NR), .IN_BITS(IB), .OUT_BITS(OB), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_x_i(req_x),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .inv_start_o(inv_start), .inv_x_o(inv_x),
    .inv_busy_i(inv_busy), .inv_done_i(inv_done), .inv_valid_i(inv_valid),
    .inv_dbz_i(inv_dbz), .inv_ovf_i(inv_ovf), .inv_y_i(inv_y),
    .busy_o(busy), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural reciprocal unit: Q.8 in, Q.35 out, fixed latency.
  function automatic recip_result_t recip_model(input logic [IB-1:0] x);
    recip_result_t r;
    longint xl, q;
    xl = longint'($signed(x));
    r  = '0;
    if (xl == 0) begin
      r.dbz = 1'b1;
    end else begin
      q = (longint'(1) <<< 43) / xl;
      if (q > (longint'(1) <<< 35) - 1 || q < -(longint'(1) <<< 35)) r.ovf = 1'b1;
      else begin
        r.y  = 36'(q);
        r.ok = 1'b1;
      end
    end
    return r;
  endfunction

  int            m_cnt;
  recip_result_t m_res;
  logic          m_hang = 1'b0;
  logic          m_extra_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_res <= '0;
    end else if (inv_start) begin
      m_cnt <= LAT;
      m_res <= recip_model(inv_x);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign inv_busy  = (m_cnt != 0);
  assign inv_done  = ((m_cnt == 1) && !m_hang) || m_extra_done;
  assign inv_y     = m_res.y;
  assign inv_valid = m_res.ok;
  assign inv_dbz   = m_res.dbz;
  assign inv_ovf   = m_res.ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic recip_result_t slot(input int lane);
    logic [NR*RW-1:0] d;
    d = resp_data;
    return recip_result_t'(d[lane*RW +: RW]);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = '0; resp_ready = '0; m_hang = 1'b0; m_extra_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) at negedge+1 for req_ready on lane; returns 1 when accepted.
  task automatic wait_accept(input int lane, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[lane]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_seen", longint'(got), 1);
  endtask

  typedef struct {
    int                     lane;
    logic signed [IB-1:0]   x;
    logic signed [OB-1:0]   y;
    logic                   ok, dbz, ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input string tag);
    bit got;
    int lat;
    recip_result_t r;
    @(negedge clk);
    req_valid[v.lane] = 1'b1;
    req_x[v.lane*IB +: IB] = v.x;
    wait_accept(v.lane, got);
    if (!got) begin req_valid = '0; return; end
    chk({tag, "_ready_onehot"}, longint'(req_ready), longint'(1) << v.lane);
    @(negedge clk);
    req_valid[v.lane] = 1'b0;
    #1;
    chk({tag, "_start"}, longint'(inv_start), 1);
    chk({tag, "_ready_drop"}, longint'(req_ready), 0);
    chk({tag, "_inv_x"}, longint'($signed(inv_x)), longint'(v.x));
    lat = 0;
    while (!resp_valid[v.lane] && lat < 100) begin
      @(negedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, LAT + 1);
    r = slot(v.lane);
    chk({tag, "_y"}, longint'(r.y), longint'(v.y));
    chk({tag, "_flags"}, longint'({r.ok, r.dbz, r.ovf}), longint'({v.ok, v.dbz, v.ovf}));
    resp_ready[v.lane] = 1'b1;
    @(negedge clk);
    resp_ready[v.lane] = 1'b0;
    #1;
    chk({tag, "_drained"}, longint'(resp_valid[v.lane]), 0);
  endtask

  initial begin : main
    int g0, g1, ovl, ng;
    int order[8];
    bit got;
    recip_result_t r;

    vecs[0] = '{lane: 0, x: 40'sd512,  y: 36'sd17179869184,  ok: 1, dbz: 0, ovf: 0};
    vecs[1] = '{lane: 1, x: 40'sd0,    y: 36'sd0,            ok: 0, dbz: 1, ovf: 0};
    vecs[2] = '{lane: 1, x: 40'sd1024, y: 36'sd8589934592,   ok: 1, dbz: 0, ovf: 0};
    vecs[3] = '{lane: 0, x: 40'sd256,  y: 36'sd0,            ok: 0, dbz: 0, ovf: 1};
    vecs[4] = '{lane: 1, x: -40'sd512, y: -36'sd17179869184, ok: 1, dbz: 0, ovf: 0};
    vecs[5] = '{lane: 0, x: 40'sd768,  y: 36'sd11453246122,  ok: 1, dbz: 0, ovf: 0};
    vecs[6] = '{lane: 1, x: 40'sd1,    y: 36'sd0,            ok: 0, dbz: 0, ovf: 1};
    vecs[7] = '{lane: 0, x: -40'sd256, y: -36'sd34359738368, ok: 1, dbz: 0, ovf: 0};

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_resp_valid", longint'(resp_valid), 0);
    chk("rst_resp_data", longint'(resp_data != '0), 0);
    chk("rst_inv_start", longint'(inv_start), 0);
    chk("rst_inv_x", longint'(inv_x), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_err", longint'(err_timeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-lane table vectors (incl. dbz on lane1 followed by a normal lane1 request)
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both lanes continuously requesting, slots always drained
    pulse_reset();
    @(negedge clk);
    req_x = {40'sd512, 40'sd1024};
    req_valid = 2'b11; resp_ready = 2'b11;
    ng = 0; ovl = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (inv_start && inv_busy) ovl++;
      if (|req_ready && ng < 8) begin order[ng] = req_ready[1] ? 1 : 0; ng++; end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (i < ng) ? order[i] : -1, i % 2);
    chk("start_busy_overlap", ovl, 0);
    req_valid = '0;
    repeat (30) @(negedge clk);

    // Lane0 slot held full: lane0 granted once, lane1 keeps going
    pulse_reset();
    @(negedge clk);
    req_valid = 2'b11; resp_ready = 2'b10;
    g0 = 0; g1 = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (req_ready[0]) g0++;
      if (req_ready[1]) g1++;
      @(negedge clk);
    end
    #1;
    chk("block_lane0_grants", g0, 1);
    chk("block_lane1_ge3", longint'(g1 >= 3), 1);
    chk("block_lane0_full", longint'(resp_valid[0]), 1);
    req_valid = '0;
    resp_ready = 2'b11;
    repeat (30) @(negedge clk);

    // Timeout: inv never completes
    pulse_reset();
    m_hang = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_x[IB +: IB] = 40'sd512;
    wait_accept(1, got);
    @(negedge clk);
    req_valid = '0;
    repeat (64) @(negedge clk);
    #1;
    chk("to_not_early", longint'(resp_valid[1]), 0);
    chk("to_err_not_early", longint'(err_timeout), 0);
    @(negedge clk); #1;
    chk("to_resp_valid", longint'(resp_valid[1]), 1);
    r = slot(1);
    chk("to_y", longint'(r.y), 0);
    chk("to_flags", longint'({r.ok, r.dbz, r.ovf}), 0);
    chk("to_err", longint'(err_timeout), 1);
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = '0;
    #1;
    chk("to_idle", longint'(busy), 0);
    chk("to_err_sticky", longint'(err_timeout), 1);
    m_hang = 1'b0;

    // Reset mid-WAIT, then a late done pulse must be ignored
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_x[0 +: IB] = 40'sd1024;
    wait_accept(0, got);
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", longint'(resp_valid), 0);
    chk("mid_rst_inv_start", longint'(inv_start), 0);
    chk("mid_rst_inv_x", longint'(inv_x), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_err", longint'(err_timeout), 0);
    chk("mid_rst_data", longint'(resp_data != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_extra_done = 1'b1;
    @(negedge clk);
    m_extra_done = 1'b0;
    g0 = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (resp_valid != '0 || busy) g0++;
      @(negedge clk);
    end
    chk("late_done_ignored", g0, 0);
    run_vec(vecs[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule
